memctrl: RTL and testbench

MEMCTRL -- requirements
Module: memctrl

---
 rtl/memctrl.sv | 150 +++++++++++++++
 tb/tb_memctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl.sv
// rtl/memctrl.sv - byte-serial RAM controller arbitrating a data port and an instruction port.
// Optional IO-full write stall enabled by defining MEMCTRL_IO_FULL_STALL_EN.
module memctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        den_i,
  input  logic        drw_i,
  input  logic [2:0]  dwidth_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddata_i,
  output logic        drdy_o,
  output logic [31:0] ddata_o,
  input  logic        ien_i,
  input  logic [31:0] iaddr_i,
  output logic        irdy_o,
  output logic [31:0] idata_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        dport_q, dport_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wshift;
  logic        width_ok;
  logic        d_block;
  logic        grant_d;
  logic        grant_i;

  assign width_ok = (dwidth_i == 3'd1) || (dwidth_i == 3'd2) || (dwidth_i == 3'd4);

`ifdef MEMCTRL_IO_FULL_STALL_EN
  assign d_block = !drw_i && (daddr_i[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign d_block = 1'b0;
`endif

  assign grant_d = den_i && !d_block;
  assign grant_i = ien_i && !grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dport_q <= 1'b0;
      n_q     <= 3'd0;
      k_q     <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q <= state_d;
      dport_q <= dport_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bad widths run the read path with zero bytes, giving DONE in cycle 1 with data 0.
  always_comb begin
    state_d = state_q;
    dport_d = dport_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          dport_d = 1'b1;
          addr_d  = daddr_i;
          wdata_d = ddata_i;
          rdata_d = 32'd0;
          k_d     = 3'd0;
          n_d     = width_ok ? dwidth_i : 3'd0;
          state_d = (drw_i || !width_ok) ? S_READ : S_WRITE;
        end else if (grant_i) begin
          dport_d = 1'b0;
          addr_d  = iaddr_i;
          wdata_d = 32'd0;
          rdata_d = 32'd0;
          k_d     = 3'd0;
          n_d     = 3'd4;
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        k_d = k_q + 3'd1;
        if (k_q == n_q - 3'd1) state_d = S_DONE;
      end
      S_READ: begin
        if (k_q != 3'd0)
          rdata_d = rdata_q | ({24'd0, mem_din} << {k_q - 3'd1, 3'b000});
        if (k_q == n_q) state_d = S_DONE;
        else k_d = k_q + 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wshift = wdata_q >> {k_q[1:0], 3'b000};

  // A stalled read re-addresses the previous byte so mem_din still holds it on resume.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    drdy_o   = 1'b0;
    irdy_o   = 1'b0;
    ddata_o  = 32'd0;
    idata_o  = 32'd0;
    case (state_q)
      S_WRITE: begin
        mem_a    = addr_q + {29'd0, k_q};
        mem_dout = wshift[7:0];
        mem_wr   = rdy && !rst;
      end
      S_READ: begin
        if (!rdy && (k_q != 3'd0)) mem_a = addr_q + {29'd0, k_q} - 32'd1;
        else if (k_q < n_q)        mem_a = addr_q + {29'd0, k_q};
      end
      S_DONE: begin
        if (rdy) begin
          drdy_o  = dport_q;
          irdy_o  = !dport_q;
          ddata_o = dport_q ? rdata_q : 32'd0;
          idata_o = dport_q ? 32'd0 : rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memctrl.sv
// tb/tb_memctrl.sv - self-checking bench for memctrl: directed table, corner sequences, random traffic.
module tb_memctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        den_i = 1'b0;
  logic        drw_i = 1'b0;
  logic [2:0]  dwidth_i = 3'd0;
  logic [31:0] daddr_i = 32'd0;
  logic [31:0] ddata_i = 32'd0;
  logic        drdy_o;
  logic [31:0] ddata_o;
  logic        ien_i = 1'b0;
  logic [31:0] iaddr_i = 32'd0;
  logic        irdy_o;
  logic [31:0] idata_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  memctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .den_i(den_i), .drw_i(drw_i), .dwidth_i(dwidth_i), .daddr_i(daddr_i), .ddata_i(ddata_i),
    .drdy_o(drdy_o), .ddata_o(ddata_o),
    .ien_i(ien_i), .iaddr_i(iaddr_i), .irdy_o(irdy_o), .idata_o(idata_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM device (4 KiB window, address aliased on the low 12 bits) with one-cycle read latency.
  logic [7:0]  dev [0:4095];
  logic        load_en = 1'b0;
  logic [11:0] load_a = 12'd0;
  logic [7:0]  load_d = 8'd0;

  always @(posedge clk) begin
    if (load_en) dev[load_a] <= load_d;
    else if (mem_wr) dev[mem_a[11:0]] <= mem_dout;
    mem_din <= dev[mem_a[11:0]];
  end

  // Reference memory contents, same aliasing, updated only from expected writes.
  logic [7:0] ref_mem [0:4095];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'd0;
    for (int k = 0; k < n; k++) begin
      t = a + k;
      r[8*k +: 8] = ref_mem[t[11:0]];
    end
    return r;
  endfunction

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_a = a; load_d = d; ref_mem[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One transaction: each cycle with rdy=1 advances the expected byte sequence by one step.
  task automatic run_txn(input string nm, input bit dp, input bit rd, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input logic [15:0] stall,
                         input bit both, input bit iobf, input int exp_lat, input logic [31:0] exp_data);
    bit valid_w, eff_rd, done;
    int n, total, p, lat;
    logic [31:0] t;
    logic [7:0] b;
    valid_w = !dp || (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
    n = !dp ? 4 : (valid_w ? int'(w) : 0);
    eff_rd = !dp || rd || !valid_w;
    total = eff_rd ? n + 1 : n;
    @(negedge clk);
    io_buffer_full = iobf;
    if (dp) begin
      den_i = 1'b1; drw_i = rd; dwidth_i = w; daddr_i = a; ddata_i = wd;
      if (both) begin ien_i = 1'b1; iaddr_i = 32'h100; end
    end else begin
      ien_i = 1'b1; iaddr_i = a;
    end
    p = 0; done = 1'b0; lat = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1 rdy = (i < 16) ? !stall[i] : 1'b1;
      @(negedge clk);
      if (!rdy) begin
        chk({nm, "_stall_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({nm, "_stall_pulse"}, {30'd0, drdy_o, irdy_o}, 32'd0);
      end else if (p == total) begin
        chk({nm, "_pulse"}, {30'd0, drdy_o, irdy_o}, dp ? 32'd2 : 32'd1);
        chk({nm, "_data"}, dp ? ddata_o : idata_o, exp_data);
        chk({nm, "_done_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({nm, "_done_a"}, mem_a, 32'd0);
        lat = i; done = 1'b1;
        if (dp) den_i = 1'b0; else ien_i = 1'b0;
      end else begin
        chk({nm, "_early_pulse"}, {30'd0, drdy_o, irdy_o}, 32'd0);
        if (p < n) begin
          t = a + p;
          chk({nm, "_addr"}, mem_a, t);
          if (eff_rd) chk({nm, "_rd_wr"}, {31'd0, mem_wr}, 32'd0);
          else begin
            b = wd[8*p +: 8];
            chk({nm, "_wr"}, {31'd0, mem_wr}, 32'd1);
            chk({nm, "_dout"}, {24'd0, mem_dout}, {24'd0, b});
            ref_mem[t[11:0]] = b;
          end
        end else begin
          chk({nm, "_gap_wr"}, {31'd0, mem_wr}, 32'd0);
        end
        p++;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no completion pulse, required one within 40 cycles", nm);
      den_i = 1'b0; ien_i = 1'b0; rdy = 1'b1;
    end else if (exp_lat >= 0) begin
      chk({nm, "_latency"}, lat, exp_lat);
    end
  endtask

  typedef struct {
    bit          dp;
    bit          rd;
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [15:0] stall;
    int          lat;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int sel, n;
    bit dp, rd, vw;
    logic [2:0] w;
    logic [31:0] a, wd, ed;
    logic [15:0] st;

    vecs[0]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0100, 32'h0,          16'h0000, 5, 32'h4433_2211};
    vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0202, 32'hAABB_CCDD, 16'h0000, 2, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0201, 32'h0,          16'h0000, 5, 32'h1FCC_DD0A};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0000, 32'h0D0C_0B0A, 16'h0006, 6, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0000, 32'h0,          16'h0000, 5, 32'h0D0C_0B0A};
    vecs[5]  = '{1'b1, 1'b1, 3'd1, 32'h0000_0203, 32'h0,          16'h0000, 2, 32'h0000_00CC};
    vecs[6]  = '{1'b1, 1'b1, 3'd3, 32'h0000_0100, 32'h0,          16'h0000, 1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'hFFFF_FFFF, 16'h0000, 1, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0,          16'h0000, 3, 32'h0000_2211};
    vecs[9]  = '{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0,          16'h0000, 5, 32'h4433_2211};
    vecs[10] = '{1'b1, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h5566_7788, 16'h0000, 4, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'd4, 32'hFFFF_FFFE, 32'h0,          16'h0000, 5, 32'h5566_7788};
    vecs[12] = '{1'b1, 1'b1, 3'd4, 32'h0000_0100, 32'h0,          16'h0011, 7, 32'h4433_2211};

    // Fill RAM with an address pattern while the controller is held in reset.
    @(negedge clk);
    load_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      load_a = 12'(i); load_d = 8'(i * 7 + 3); ref_mem[i] = 8'(i * 7 + 3);
      @(negedge clk);
    end
    load_en = 1'b0;

    chk("reset_pulses", {30'd0, drdy_o, irdy_o}, 32'd0);
    chk("reset_ddata", ddata_o, 32'd0);
    chk("reset_idata", idata_o, 32'd0);
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_dout_wr", {23'd0, mem_dout, mem_wr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_a", mem_a, 32'd0);

    load(12'h100, 8'h11); load(12'h101, 8'h22); load(12'h102, 8'h33); load(12'h103, 8'h44);

    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].dp, vecs[i].rd, vecs[i].w, vecs[i].a, vecs[i].wd,
              vecs[i].stall, 1'b0, 1'b0, vecs[i].lat, vecs[i].data);

    // Both ports at once: data first, instruction granted right after the DONE cycle.
    run_txn("both_data", 1'b1, 1'b1, 3'd4, 32'h100, 32'h0, 16'h0, 1'b1, 1'b0, 5, 32'h4433_2211);
    run_txn("both_instr", 1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 16'h0, 1'b0, 1'b0, 5, 32'h4433_2211);

    // Reset in cycle 2 of a width-4 write: bytes 0 and 1 land, nothing else.
    @(negedge clk);
    den_i = 1'b1; drw_i = 1'b0; dwidth_i = 3'd4; daddr_i = 32'h400; ddata_i = 32'h9988_7766;
    @(negedge clk);
    chk("rstmid_b0_wr", {31'd0, mem_wr}, 32'd1);
    chk("rstmid_b0_a", mem_a, 32'h400);
    ref_mem[12'h400] = 8'h66;
    @(negedge clk);
    chk("rstmid_b1_a", mem_a, 32'h401);
    ref_mem[12'h401] = 8'h77;
    @(posedge clk);
    #1 rst = 1'b1; den_i = 1'b0;
    @(negedge clk);
    chk("rstmid_c2_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_no_pulse", {30'd0, drdy_o, irdy_o}, 32'd0);
    chk("rstmid_idle_a", mem_a, 32'd0);
    run_txn("rstmid_readback", 1'b1, 1'b1, 3'd4, 32'h400, 32'h0, 16'h0, 1'b0, 1'b0, 5,
            ref_read(32'h400, 4));

`ifdef MEMCTRL_IO_FULL_STALL_EN
    @(negedge clk);
    den_i = 1'b1; drw_i = 1'b0; dwidth_i = 3'd1; daddr_i = 32'h30000; ddata_i = 32'h5A;
    io_buffer_full = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("io_blocked_wr", {31'd0, mem_wr}, 32'd0);
      chk("io_blocked_a", mem_a, 32'd0);
    end
    run_txn("io_write", 1'b1, 1'b0, 3'd1, 32'h30000, 32'h5A, 16'h0, 1'b0, 1'b0, 1, 32'h0);
`else
    run_txn("io_write", 1'b1, 1'b0, 3'd1, 32'h30000, 32'h5A, 16'h0, 1'b0, 1'b1, 1, 32'h0);
`endif
    io_buffer_full = 1'b0;
    run_txn("io_readback", 1'b1, 1'b1, 3'd1, 32'h30000, 32'h0, 16'h0, 1'b0, 1'b0, 2, 32'h5A);

    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: w = 3'd1;
        1: w = 3'd2;
        2, 3: w = 3'd4;
        4: w = 3'd3;
        default: w = 3'd0;
      endcase
      dp = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      a = $urandom;
      wd = $urandom;
      st = 16'($urandom & $urandom & $urandom);
      vw = (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
      n = !dp ? 4 : (vw ? int'(w) : 0);
      ed = (!dp || (rd && vw)) ? ref_read(a, n) : 32'd0;
      run_txn($sformatf("rnd%0d", r), dp, rd, w, a, wd, st, 1'b0, 1'b0, -1, ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 1000000");
    $fatal(1);
  end

endmodule
